// File: rtl/syn_fgyrus_pkg.sv
// Shared types and helpers for the fgyrus butterfly feeder.
package syn_fgyrus_pkg;

  localparam int DEFAULT_NUM_SAMPLES_LOG2 = 7;

  // Internal working width for address arithmetic; callers truncate.
  localparam int ADDR_MAX_W = 16;
  localparam logic [ADDR_MAX_W-1:0] ADDR_ONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_A,
    READ_B,
    DRAIN,
    WAIT_WB,
    DONE
  } fsm_state_t;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0] addr_a;
    logic [ADDR_MAX_W-1:0] addr_b;
    logic [ADDR_MAX_W-1:0] twdl_addr;
  } bfly_addr_t;

  // Operand and twiddle addresses of butterfly k in stage s of an
  // in-place radix-2 DIT transform with 2^n_log2 points.
  function automatic bfly_addr_t bfly_addr(input logic [4:0]            stage,
                                           input logic [ADDR_MAX_W-1:0] bfly,
                                           input logic [4:0]            n_log2);
    bfly_addr_t            r;
    logic [ADDR_MAX_W-1:0] span;
    logic [ADDR_MAX_W-1:0] pos;
    logic [ADDR_MAX_W-1:0] grp;
    span        = ADDR_ONE << stage;
    pos         = bfly & (span - ADDR_ONE);
    grp         = bfly >> stage;
    r.addr_a    = (grp << (stage + 5'd1)) | pos;
    r.addr_b    = r.addr_a + span;
    r.twdl_addr = pos << (n_log2 - 5'd1 - stage);
    return r;
  endfunction

endpackage

// File: rtl/syn_fgyrus_addr_gen.sv
// Combinational butterfly address generation from (stage, butterfly).
module syn_fgyrus_addr_gen
  import syn_fgyrus_pkg::*;
#(
  parameter int NUM_SAMPLES_LOG2 = DEFAULT_NUM_SAMPLES_LOG2,
  parameter int STAGE_W          = $clog2(NUM_SAMPLES_LOG2)
) (
  input  logic [STAGE_W-1:0]          stage_i,
  input  logic [NUM_SAMPLES_LOG2-2:0] bfly_i,
  output logic [NUM_SAMPLES_LOG2-1:0] addr_a_o,
  output logic [NUM_SAMPLES_LOG2-1:0] addr_b_o,
  output logic [NUM_SAMPLES_LOG2-2:0] twdl_addr_o
);

  bfly_addr_t addrs;
  logic       unused_addr_bits;

  assign addrs = bfly_addr(5'(stage_i), ADDR_MAX_W'(bfly_i), 5'(NUM_SAMPLES_LOG2));

  // Truncate to the port widths; upper bits of the working width are dropped.
  assign addr_a_o    = addrs.addr_a[NUM_SAMPLES_LOG2-1:0];
  assign addr_b_o    = addrs.addr_b[NUM_SAMPLES_LOG2-1:0];
  assign twdl_addr_o = addrs.twdl_addr[NUM_SAMPLES_LOG2-2:0];

  assign unused_addr_bits = ^addrs;

endmodule

// File: rtl/syn_fgyrus_butter_feeder.sv
// Stage/butterfly sequencer feeding operands and twiddles to the FFT butterfly.
module syn_fgyrus_butter_feeder
  import syn_fgyrus_pkg::*;
#(
  parameter int SAMPLE_W         = 32,
  parameter int TWDL_W           = 10,
  parameter int NUM_SAMPLES_LOG2 = DEFAULT_NUM_SAMPLES_LOG2,
  parameter int RAM_RD_DELAY     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fft_start,
  output logic                        fft_busy,
  output logic                        fft_done,
  input  logic                        stage_wb_done,
  output logic                        sample_rd_en,
  output logic [NUM_SAMPLES_LOG2-1:0] sample_rd_addr,
  input  logic [SAMPLE_W-1:0]         sample_rd_real,
  input  logic [SAMPLE_W-1:0]         sample_rd_im,
  output logic [NUM_SAMPLES_LOG2-2:0] twdl_rd_addr,
  input  logic [TWDL_W-1:0]           twdl_rd_real,
  input  logic [TWDL_W-1:0]           twdl_rd_im,
  output logic [SAMPLE_W-1:0]         sample_a_real,
  output logic [SAMPLE_W-1:0]         sample_a_im,
  output logic [SAMPLE_W-1:0]         sample_b_real,
  output logic [SAMPLE_W-1:0]         sample_b_im,
  output logic [TWDL_W-1:0]           twdl_real,
  output logic [TWDL_W-1:0]           twdl_im,
  output logic                        samples_rdy
);

  localparam int STAGE_W = $clog2(NUM_SAMPLES_LOG2);
  localparam int BFLY_W  = NUM_SAMPLES_LOG2 - 1;
  localparam int DRAIN_W = $clog2(RAM_RD_DELAY + 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_SAMPLES_LOG2 - 1);
  localparam logic [BFLY_W-1:0]  LAST_BFLY  = '1;
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(RAM_RD_DELAY - 1);

  fsm_state_t         state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [BFLY_W-1:0]  bfly_q, bfly_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               wb_flag_q, wb_flag_d;

  logic [RAM_RD_DELAY-1:0] pipe_valid_q;
  logic [RAM_RD_DELAY-1:0] pipe_is_b_q;

  logic                        rd_issue;
  logic                        rd_is_b;
  logic [NUM_SAMPLES_LOG2-1:0] addr_a;
  logic [NUM_SAMPLES_LOG2-1:0] addr_b;
  logic [NUM_SAMPLES_LOG2-2:0] twdl_addr;
  logic                        a_return;
  logic                        b_return;

  syn_fgyrus_addr_gen #(
    .NUM_SAMPLES_LOG2(NUM_SAMPLES_LOG2),
    .STAGE_W         (STAGE_W)
  ) u_addr_gen (
    .stage_i    (stage_q),
    .bfly_i     (bfly_q),
    .addr_a_o   (addr_a),
    .addr_b_o   (addr_b),
    .twdl_addr_o(twdl_addr)
  );

  // FSM and sequencing counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      bfly_q    <= '0;
      drain_q   <= '0;
      wb_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      bfly_q    <= bfly_d;
      drain_q   <= drain_d;
      wb_flag_q <= wb_flag_d;
    end
  end

  // Next state, read issue and status outputs.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    drain_d   = drain_q;
    wb_flag_d = wb_flag_q;
    rd_issue  = 1'b0;
    rd_is_b   = 1'b0;
    fft_busy  = 1'b1;
    fft_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        fft_busy = 1'b0;
        if (fft_start) begin
          state_d   = READ_A;
          stage_d   = '0;
          bfly_d    = '0;
          wb_flag_d = 1'b0;
        end
      end
      READ_A: begin
        rd_issue = 1'b1;
        state_d  = READ_B;
      end
      READ_B: begin
        rd_issue = 1'b1;
        rd_is_b  = 1'b1;
        if (bfly_q == LAST_BFLY) begin
          state_d = DRAIN;
          drain_d = '0;
          // Write-back may finish the stage while our last reads are in flight.
          if (stage_wb_done) wb_flag_d = 1'b1;
        end else begin
          bfly_d  = bfly_q + BFLY_W'(1);
          state_d = READ_A;
        end
      end
      DRAIN: begin
        if (stage_wb_done) wb_flag_d = 1'b1;
        if (drain_q == LAST_DRAIN) state_d = WAIT_WB;
        else drain_d = drain_q + DRAIN_W'(1);
      end
      WAIT_WB: begin
        // Same-cycle pulse counts so the next stage starts one cycle later.
        if (wb_flag_q || stage_wb_done) begin
          wb_flag_d = 1'b0;
          if (stage_q == LAST_STAGE) begin
            state_d = DONE;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
            bfly_d  = '0;
            state_d = READ_A;
          end
        end
      end
      DONE: begin
        fft_busy = 1'b0;
        fft_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read port drive; addresses idle at zero outside the read states.
  always_comb begin
    sample_rd_en   = rd_issue;
    sample_rd_addr = '0;
    twdl_rd_addr   = '0;
    if (state_q == READ_A) begin
      sample_rd_addr = addr_a;
      twdl_rd_addr   = twdl_addr;
    end else if (state_q == READ_B) begin
      sample_rd_addr = addr_b;
    end
  end

  // Tag pipe matching the RAM/ROM latency: valid plus A/B marker per read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_q <= '0;
      pipe_is_b_q  <= '0;
    end else begin
      pipe_valid_q[0] <= rd_issue;
      pipe_is_b_q[0]  <= rd_is_b;
      for (int i = 1; i < RAM_RD_DELAY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_is_b_q[i]  <= pipe_is_b_q[i-1];
      end
    end
  end

  assign a_return = pipe_valid_q[RAM_RD_DELAY-1] & ~pipe_is_b_q[RAM_RD_DELAY-1];
  assign b_return = pipe_valid_q[RAM_RD_DELAY-1] & pipe_is_b_q[RAM_RD_DELAY-1];

  // Capture returning operands; the strobe follows the B capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_a_real <= '0;
      sample_a_im   <= '0;
      sample_b_real <= '0;
      sample_b_im   <= '0;
      twdl_real     <= '0;
      twdl_im       <= '0;
      samples_rdy   <= 1'b0;
    end else begin
      if (a_return) begin
        sample_a_real <= sample_rd_real;
        sample_a_im   <= sample_rd_im;
        twdl_real     <= twdl_rd_real;
        twdl_im       <= twdl_rd_im;
      end
      if (b_return) begin
        sample_b_real <= sample_rd_real;
        sample_b_im   <= sample_rd_im;
      end
      samples_rdy <= b_return;
    end
  end

endmodule

// File: tb/tb_syn_fgyrus_butter_feeder.sv
// Directed bench: N=3, two-cycle RAM/ROM latency, table of expected butterflies.
module tb_syn_fgyrus_butter_feeder;

  localparam int SW = 32;
  localparam int TW = 10;
  localparam int NL = 3;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          fft_start;
  logic          fft_busy;
  logic          fft_done;
  logic          stage_wb_done;
  logic          sample_rd_en;
  logic [NL-1:0] sample_rd_addr;
  logic [SW-1:0] sample_rd_real;
  logic [SW-1:0] sample_rd_im;
  logic [NL-2:0] twdl_rd_addr;
  logic [TW-1:0] twdl_rd_real;
  logic [TW-1:0] twdl_rd_im;
  logic [SW-1:0] sample_a_real;
  logic [SW-1:0] sample_a_im;
  logic [SW-1:0] sample_b_real;
  logic [SW-1:0] sample_b_im;
  logic [TW-1:0] twdl_real;
  logic [TW-1:0] twdl_im;
  logic          samples_rdy;

  always #5 clk = ~clk;

  syn_fgyrus_butter_feeder #(
    .SAMPLE_W(SW), .TWDL_W(TW), .NUM_SAMPLES_LOG2(NL), .RAM_RD_DELAY(D)
  ) dut (
    .clk(clk), .rst(rst), .fft_start(fft_start), .fft_busy(fft_busy),
    .fft_done(fft_done), .stage_wb_done(stage_wb_done),
    .sample_rd_en(sample_rd_en), .sample_rd_addr(sample_rd_addr),
    .sample_rd_real(sample_rd_real), .sample_rd_im(sample_rd_im),
    .twdl_rd_addr(twdl_rd_addr), .twdl_rd_real(twdl_rd_real), .twdl_rd_im(twdl_rd_im),
    .sample_a_real(sample_a_real), .sample_a_im(sample_a_im),
    .sample_b_real(sample_b_real), .sample_b_im(sample_b_im),
    .twdl_real(twdl_real), .twdl_im(twdl_im), .samples_rdy(samples_rdy)
  );

  // RAM returns data=address, ROM returns address+100 (imag parts offset further).
  logic [NL-1:0] ram_pipe [D];
  logic [NL-2:0] rom_pipe [D];
  always @(posedge clk) begin
    ram_pipe[0] <= sample_rd_addr;
    rom_pipe[0] <= twdl_rd_addr;
    for (int i = 1; i < D; i++) begin
      ram_pipe[i] <= ram_pipe[i-1];
      rom_pipe[i] <= rom_pipe[i-1];
    end
  end
  assign sample_rd_real = SW'(ram_pipe[D-1]);
  assign sample_rd_im   = SW'(ram_pipe[D-1]) + 32'd1000;
  assign twdl_rd_real   = TW'(rom_pipe[D-1]) + 10'd100;
  assign twdl_rd_im     = TW'(rom_pipe[D-1]) + 10'd200;

  typedef struct {
    int cyc;
    int addr;
    int tw;
  } rd_ev_t;

  typedef struct {
    int          cyc;
    logic [63:0] ar, ai, br, bi, tr, ti;
  } st_ev_t;

  typedef struct {
    int a;
    int b;
    int tw;
  } vec_t;

  rd_ev_t rd_q[$];
  st_ev_t st_q[$];
  vec_t   vecs[12];
  int     cyc = 0;
  int     done_cnt = 0;
  int     done_cyc = -1;
  int     n_cmp = 0;
  int     n_fail = 0;

  // Log reads, strobes and done pulses with the cycle they occur in.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sample_rd_en === 1'b1)
      rd_q.push_back('{cyc, int'(sample_rd_addr), int'(twdl_rd_addr)});
    if (samples_rdy === 1'b1)
      st_q.push_back('{cyc, 64'(sample_a_real), 64'(sample_a_im), 64'(sample_b_real),
                       64'(sample_b_im), 64'(twdl_real), 64'(twdl_im)});
    if (fft_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, 64'(sample_rd_en), 0);
    chk({tag, "_rd_addr"}, 64'(sample_rd_addr), 0);
    chk({tag, "_twdl_addr"}, 64'(twdl_rd_addr), 0);
    chk({tag, "_busy"}, 64'(fft_busy), 0);
    chk({tag, "_done"}, 64'(fft_done), 0);
    chk({tag, "_rdy"}, 64'(samples_rdy), 0);
    chk({tag, "_a"}, {sample_a_real, sample_a_im}, 0);
    chk({tag, "_b"}, {sample_b_real, sample_b_im}, 0);
    chk({tag, "_twdl"}, 64'({twdl_real, twdl_im}), 0);
  endtask

  task automatic wait_rd(input int n, input int budget);
    int t = 0;
    while (rd_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("wait_reads", 64'(rd_q.size()), 64'(n));
  endtask

  task automatic wait_st(input int n, input int budget);
    int t = 0;
    while (st_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("wait_strobes", 64'(st_q.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cyc, wb0_cyc, c;
    rst = 1'b1;
    fft_start = 1'b0;
    stage_wb_done = 1'b0;
    vecs[0]  = '{0, 1, 0}; vecs[1]  = '{2, 3, 0}; vecs[2]  = '{4, 5, 0}; vecs[3]  = '{6, 7, 0};
    vecs[4]  = '{0, 2, 0}; vecs[5]  = '{1, 3, 2}; vecs[6]  = '{4, 6, 0}; vecs[7]  = '{5, 7, 2};
    vecs[8]  = '{0, 4, 0}; vecs[9]  = '{1, 5, 1}; vecs[10] = '{2, 6, 2}; vecs[11] = '{3, 7, 3};

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 64'(fft_busy), 0);
    rd_q.delete(); st_q.delete();

    // Full transform with a late stage-0 write-back and an ignored restart.
    fft_start = 1'b1; start_cyc = cyc;
    @(negedge clk); fft_start = 1'b0;
    chk("busy_after_start", 64'(fft_busy), 1);
    chk("first_read_addr", 64'(sample_rd_addr), 0);
    repeat (2) @(negedge clk);
    fft_start = 1'b1;
    @(negedge clk); fft_start = 1'b0;
    wait_st(4, 100);
    repeat (20) @(negedge clk);
    chk("gap_reads", 64'(rd_q.size()), 8);
    chk("gap_strobes", 64'(st_q.size()), 4);
    chk("busy_in_wait", 64'(fft_busy), 1);
    stage_wb_done = 1'b1; wb0_cyc = cyc;
    @(negedge clk); stage_wb_done = 1'b0;

    // Stage 1: write-back pulse lands in the first drain cycle.
    wait_rd(16, 100);
    @(negedge clk); stage_wb_done = 1'b1;
    @(negedge clk); stage_wb_done = 1'b0;

    // Stage 2: pulse in the final READ_B; start during DONE is ignored.
    wait_rd(24, 100);
    stage_wb_done = 1'b1;
    @(negedge clk); stage_wb_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_pulse", 64'(fft_done), 1);
    chk("busy_in_done", 64'(fft_busy), 0);
    fft_start = 1'b1;
    @(negedge clk); fft_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_after_done", 64'(fft_busy), 0);
    chk("reads_after_done", 64'(rd_q.size()), 24);
    chk("done_count", 64'(done_cnt), 1);
    chk("done_cycle", 64'(done_cyc), 64'(rd_q[23].cyc + 4));

    chk("first_read_cycle", 64'(rd_q[0].cyc), 64'(start_cyc + 1));
    chk("stage1_start", 64'(rd_q[8].cyc), 64'(wb0_cyc + 1));
    chk("stage2_start", 64'(rd_q[16].cyc), 64'(rd_q[15].cyc + 4));
    chk("strobe_count", 64'(st_q.size()), 12);
    for (int i = 0; i < 12; i++) begin
      if (rd_q.size() >= 2 * i + 2 && st_q.size() >= i + 1) begin
        $display("bfly %0d: rd A=%0d tw=%0d B=%0d | rdy cyc=%0d A=%0d B=%0d tw=%0d",
                 i, rd_q[2*i].addr, rd_q[2*i].tw, rd_q[2*i+1].addr,
                 st_q[i].cyc, st_q[i].ar, st_q[i].br, st_q[i].tr);
        chk("rd_addr_a", 64'(rd_q[2*i].addr), 64'(vecs[i].a));
        chk("rd_twdl", 64'(rd_q[2*i].tw), 64'(vecs[i].tw));
        chk("rd_addr_b", 64'(rd_q[2*i+1].addr), 64'(vecs[i].b));
        chk("rd_b_cycle", 64'(rd_q[2*i+1].cyc), 64'(rd_q[2*i].cyc + 1));
        if (i % 4 != 0)
          chk("rd_a_cycle", 64'(rd_q[2*i].cyc), 64'(rd_q[2*i-1].cyc + 1));
        chk("rdy_cycle", 64'(st_q[i].cyc), 64'(rd_q[2*i+1].cyc + D + 1));
        chk("a_real", st_q[i].ar, 64'(vecs[i].a));
        chk("a_im", st_q[i].ai, 64'(vecs[i].a + 1000));
        chk("b_real", st_q[i].br, 64'(vecs[i].b));
        chk("b_im", st_q[i].bi, 64'(vecs[i].b + 1000));
        chk("twdl_real", st_q[i].tr, 64'(vecs[i].tw + 100));
        chk("twdl_im", st_q[i].ti, 64'(vecs[i].tw + 200));
      end
    end

    // Reset during stage 1, then restart from stage 0.
    rd_q.delete(); st_q.delete();
    fft_start = 1'b1;
    @(negedge clk); fft_start = 1'b0;
    wait_st(4, 100);
    stage_wb_done = 1'b1;
    @(negedge clk); stage_wb_done = 1'b0;
    wait_rd(10, 100);
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 64'(fft_busy), 0);
    rd_q.delete(); st_q.delete();
    fft_start = 1'b1; c = cyc;
    @(negedge clk); fft_start = 1'b0;
    chk("restart_rd_en", 64'(sample_rd_en), 1);
    chk("restart_addr_a", 64'(sample_rd_addr), 0);
    chk("restart_twdl", 64'(twdl_rd_addr), 0);
    chk("restart_busy", 64'(fft_busy), 1);
    chk("restart_cycle", 64'(rd_q.size() > 0 ? rd_q[0].cyc : -1), 64'(c + 1));
    @(negedge clk);
    chk("restart_addr_b", 64'(sample_rd_addr), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
